// File: rtl/hazard_if.sv
// Pipeline <-> hazard unit signal bundle: pipeline-register fields in, stall/flush/forward controls out.
// master = pipeline side, slave = hazard unit side.
interface hazard_if;
    logic [31:0] IFID_inst;
    logic [4:0]  IDEX_inst25_21;
    logic [4:0]  IDEX_inst20_16;
    logic        IDEX_mem_read;
    logic [4:0]  EXMEM_WriteRegister;
    logic        EXMEM_reg_write;
    logic [4:0]  MEMWB_WriteRegister;
    logic        MEMWB_reg_write;
    logic        EXMEM_branch_taken;
    logic        EXMEM_mem_access;
    logic        dmem_ready;

    logic        pc_write;
    logic        IFID_write;
    logic        IDEX_bubble;
    logic        IFID_flush;
    logic        IDEX_flush;
    logic        EXMEM_flush;
    logic        freeze;
    logic        MEMWB_bubble;
    logic        mem_timeout;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
    logic [0:0]  dbg_state;

    modport master (
        output IFID_inst, IDEX_inst25_21, IDEX_inst20_16, IDEX_mem_read,
               EXMEM_WriteRegister, EXMEM_reg_write, MEMWB_WriteRegister, MEMWB_reg_write,
               EXMEM_branch_taken, EXMEM_mem_access, dmem_ready,
        input  pc_write, IFID_write, IDEX_bubble, IFID_flush, IDEX_flush, EXMEM_flush,
               freeze, MEMWB_bubble, mem_timeout, forward_a, forward_b,
               stall_cycles, flush_count, dbg_state
    );

    modport slave (
        input  IFID_inst, IDEX_inst25_21, IDEX_inst20_16, IDEX_mem_read,
               EXMEM_WriteRegister, EXMEM_reg_write, MEMWB_WriteRegister, MEMWB_reg_write,
               EXMEM_branch_taken, EXMEM_mem_access, dmem_ready,
        output pc_write, IFID_write, IDEX_bubble, IFID_flush, IDEX_flush, EXMEM_flush,
               freeze, MEMWB_bubble, mem_timeout, forward_a, forward_b,
               stall_cycles, flush_count, dbg_state
    );
endinterface

// File: rtl/hazard_unit.sv
// 5-stage pipeline hazard unit: memory-wait freeze, branch flush, load-use stall, operand forwarding.
// Optional performance counters compiled in with `define HAZARD_PERF_EN.
module hazard_unit #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic    clk,
    input  logic    reset,
    hazard_if.slave hz
);
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;
    localparam logic [7:0] LIMIT    = WAIT_LIMIT[7:0];

    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_inc;
    logic       r_mem_timeout;
    logic [4:0] w_ifid_rs;
    logic [4:0] w_ifid_rt;
    logic       w_load_use;
    logic       w_frozen;
    logic       w_branch_flush;
    logic       w_load_stall;
    logic       w_pc_write;
    logic       w_unused_inst;

    assign w_ifid_rs     = hz.IFID_inst[25:21];
    assign w_ifid_rt     = hz.IFID_inst[20:16];
    assign w_unused_inst = ^{hz.IFID_inst[31:26], hz.IFID_inst[15:0]};

    assign w_load_use = hz.IDEX_mem_read && (hz.IDEX_inst20_16 != 5'd0) &&
                        ((hz.IDEX_inst20_16 == w_ifid_rs) || (hz.IDEX_inst20_16 == w_ifid_rt));

    // Priority is carried by the masks: freeze beats branch flush beats load-use stall.
    // Every control term is gated by reset so the whole block is quiet while reset is low.
    assign w_frozen       = reset && ((r_state == MEM_WAIT) || hz.EXMEM_mem_access) && !hz.dmem_ready;
    assign w_branch_flush = reset && !w_frozen && hz.EXMEM_branch_taken;
    assign w_load_stall   = reset && !w_frozen && !w_branch_flush && w_load_use;
    assign w_pc_write     = reset && !w_frozen && !w_load_stall;

    assign hz.pc_write     = w_pc_write;
    assign hz.IFID_write   = w_pc_write;
    assign hz.IDEX_bubble  = w_load_stall;
    assign hz.IFID_flush   = w_branch_flush;
    assign hz.IDEX_flush   = w_branch_flush;
    assign hz.EXMEM_flush  = w_branch_flush;
    assign hz.freeze       = w_frozen;
    assign hz.MEMWB_bubble = w_frozen;
    assign hz.mem_timeout  = r_mem_timeout;
    assign hz.dbg_state    = r_state;

    function automatic logic [1:0] fwd_sel(input logic en, input logic [4:0] src,
                                           input logic ex_we, input logic [4:0] ex_rd,
                                           input logic wb_we, input logic [4:0] wb_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (en && ex_we && (ex_rd != 5'd0) && (ex_rd == src)) begin
            sel = 2'b10;
        end else if (en && wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign hz.forward_a = fwd_sel(reset, hz.IDEX_inst25_21, hz.EXMEM_reg_write,
                                  hz.EXMEM_WriteRegister, hz.MEMWB_reg_write, hz.MEMWB_WriteRegister);
    assign hz.forward_b = fwd_sel(reset, hz.IDEX_inst20_16, hz.EXMEM_reg_write,
                                  hz.EXMEM_WriteRegister, hz.MEMWB_reg_write, hz.MEMWB_WriteRegister);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:      if (hz.EXMEM_mem_access && !hz.dmem_ready) w_state_next = MEM_WAIT;
            MEM_WAIT: if (hz.dmem_ready) w_state_next = RUN;
            default:  w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counts every cycle spent in MEM_WAIT, including the one in which memory answers.
    assign w_wait_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else if (r_state == RUN) begin
            r_wait_cnt <= 8'd0;
        end else begin
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc >= LIMIT) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= 16'd0;
            r_flush_count  <= 16'd0;
        end else begin
            if (!w_pc_write && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_branch_flush && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign hz.stall_cycles = r_stall_cycles;
    assign hz.flush_count  = r_flush_count;
`else
    assign hz.stall_cycles = 16'd0;
    assign hz.flush_count  = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (WAIT_LIMIT=4): vector table for combinational control plus
// hand sequences for memory wait, timeout and asynchronous reset.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic reset;

    hazard_if hz();

    hazard_unit #(.WAIT_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [4:0] ifid_rs;
        logic [4:0] ifid_rt;
        logic [4:0] idex_rs;
        logic [4:0] idex_rt;
        logic       mem_read;
        logic [4:0] ex_wr;
        logic       ex_we;
        logic [4:0] wb_wr;
        logic       wb_we;
        logic       br;
        logic       acc;
        logic       rdy;
        logic       e_pc;
        logic       e_ifw;
        logic       e_bub;
        logic       e_fl;
        logic       e_frz;
        logic       e_wbb;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
    } vec_t;

    vec_t vecs[14];
    int   checks    = 0;
    int   failures  = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        hz.IFID_inst           = 32'd0;
        hz.IDEX_inst25_21      = 5'd0;
        hz.IDEX_inst20_16      = 5'd0;
        hz.IDEX_mem_read       = 1'b0;
        hz.EXMEM_WriteRegister = 5'd0;
        hz.EXMEM_reg_write     = 1'b0;
        hz.MEMWB_WriteRegister = 5'd0;
        hz.MEMWB_reg_write     = 1'b0;
        hz.EXMEM_branch_taken  = 1'b0;
        hz.EXMEM_mem_access    = 1'b0;
        hz.dmem_ready          = 1'b1;
    endtask

    task automatic drive_vec(input vec_t v);
        hz.IFID_inst           = {6'd0, v.ifid_rs, v.ifid_rt, 16'd0};
        hz.IDEX_inst25_21      = v.idex_rs;
        hz.IDEX_inst20_16      = v.idex_rt;
        hz.IDEX_mem_read       = v.mem_read;
        hz.EXMEM_WriteRegister = v.ex_wr;
        hz.EXMEM_reg_write     = v.ex_we;
        hz.MEMWB_WriteRegister = v.wb_wr;
        hz.MEMWB_reg_write     = v.wb_we;
        hz.EXMEM_branch_taken  = v.br;
        hz.EXMEM_mem_access    = v.acc;
        hz.dmem_ready          = v.rdy;
    endtask

    task automatic check_ctrl(input string tag, input logic pc, input logic ifw, input logic bub,
                              input logic fl, input logic frz, input logic wbb);
        check({tag, " pc_write"},     32'(hz.pc_write),     32'(pc));
        check({tag, " IFID_write"},   32'(hz.IFID_write),   32'(ifw));
        check({tag, " IDEX_bubble"},  32'(hz.IDEX_bubble),  32'(bub));
        check({tag, " IFID_flush"},   32'(hz.IFID_flush),   32'(fl));
        check({tag, " IDEX_flush"},   32'(hz.IDEX_flush),   32'(fl));
        check({tag, " EXMEM_flush"},  32'(hz.EXMEM_flush),  32'(fl));
        check({tag, " freeze"},       32'(hz.freeze),       32'(frz));
        check({tag, " MEMWB_bubble"}, 32'(hz.MEMWB_bubble), 32'(wbb));
    endtask

    task automatic check_perf(input string tag);
        check({tag, " stall_cycles"}, 32'(hz.stall_cycles), PERF ? 32'(exp_stall) : 32'd0);
        check({tag, " flush_count"},  32'(hz.flush_count),  PERF ? 32'(exp_flush) : 32'd0);
    endtask

    initial begin
        // ifid_rs ifid_rt idex_rs idex_rt mr | ex_wr ex_we wb_wr wb_we | br acc rdy || pc ifw bub fl frz wbb fa fb
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[1]  = '{5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[2]  = '{5'd0, 5'd9, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[4]  = '{5'd6, 5'd0, 5'd0, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[5]  = '{5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[6]  = '{5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
        vecs[7]  = '{5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
        vecs[8]  = '{5'd0, 5'd0, 5'd3, 5'd3, 1'b0, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01};
        vecs[9]  = '{5'd0, 5'd0, 5'd4, 5'd8, 1'b0, 5'd8, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[12] = '{5'd0, 5'd2, 5'd2, 5'd2, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10};
        vecs[13] = '{5'd0, 5'd0, 5'd1, 5'd0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00};

        // Reset: inputs that would otherwise freeze and forward must be masked.
        reset = 1'b0;
        set_idle();
        hz.EXMEM_mem_access    = 1'b1;
        hz.dmem_ready          = 1'b0;
        hz.EXMEM_WriteRegister = 5'd5;
        hz.EXMEM_reg_write     = 1'b1;
        hz.IDEX_inst25_21      = 5'd5;
        repeat (3) @(negedge clk);
        #1;
        check_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset forward_a", 32'(hz.forward_a), 32'd0);
        check("reset forward_b", 32'(hz.forward_b), 32'd0);
        check("reset mem_timeout", 32'(hz.mem_timeout), 32'd0);
        check("reset state", 32'(hz.dbg_state), 32'd0);
        check_perf("reset");

        @(negedge clk);
        set_idle();
        reset = 1'b1;
        #1;
        check("release pc_write", 32'(hz.pc_write), 32'd1);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            #1;
            check_ctrl($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ifw, vecs[i].e_bub,
                       vecs[i].e_fl, vecs[i].e_frz, vecs[i].e_wbb);
            check($sformatf("v%0d forward_a", i), 32'(hz.forward_a), 32'(vecs[i].e_fa));
            check($sformatf("v%0d forward_b", i), 32'(hz.forward_b), 32'(vecs[i].e_fb));
            if (!vecs[i].e_pc) exp_stall++;
            if (vecs[i].e_fl) exp_flush++;
        end
        @(negedge clk);
        set_idle();
        #1;
        check_perf("table");

        // add $3,$2,$4 in IF/ID behind a load to $2: one-cycle stall.
        @(negedge clk);
        hz.IFID_inst      = 32'h0044_1820;
        hz.IDEX_mem_read  = 1'b1;
        hz.IDEX_inst20_16 = 5'd2;
        #1;
        check_ctrl("lw-add", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_stall++;
        @(negedge clk);
        hz.IDEX_mem_read = 1'b0;
        #1;
        check_ctrl("lw-add next", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_perf("lw-add");

        // Memory wait of 3 cycles; first cycle also has a taken branch and load-use, freeze wins.
        @(negedge clk);
        hz.IDEX_mem_read      = 1'b1;
        hz.EXMEM_branch_taken = 1'b1;
        hz.EXMEM_mem_access   = 1'b1;
        hz.dmem_ready         = 1'b0;
        #1;
        check_ctrl("wait0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("wait0 state", 32'(hz.dbg_state), 32'd0);
        exp_stall++;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            hz.EXMEM_branch_taken = 1'b0;
            hz.IDEX_mem_read      = 1'b0;
            #1;
            check_ctrl($sformatf("wait%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            check($sformatf("wait%0d state", k), 32'(hz.dbg_state), 32'd1);
            exp_stall++;
        end
        @(negedge clk);
        hz.EXMEM_mem_access = 1'b0;
        hz.dmem_ready       = 1'b1;
        #1;
        check_ctrl("wait done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("wait back state", 32'(hz.dbg_state), 32'd0);
        check("wait mem_timeout", 32'(hz.mem_timeout), 32'd0);
        check_perf("wait");

        // Six-cycle wait with limit 4: timeout visible after the 4th MEM_WAIT cycle, then sticky.
        @(negedge clk);
        set_idle();
        hz.EXMEM_mem_access = 1'b1;
        hz.dmem_ready       = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check($sformatf("tmo%0d freeze", k), 32'(hz.freeze), 32'd1);
            check($sformatf("tmo%0d mem_timeout", k), 32'(hz.mem_timeout), (k >= 5) ? 32'd1 : 32'd0);
            exp_stall++;
        end
        @(negedge clk);
        hz.EXMEM_mem_access = 1'b0;
        hz.dmem_ready       = 1'b1;
        #1;
        check("tmo ready freeze", 32'(hz.freeze), 32'd0);
        check("tmo ready mem_timeout", 32'(hz.mem_timeout), 32'd1);
        @(negedge clk);
        #1;
        check("tmo sticky", 32'(hz.mem_timeout), 32'd1);
        check("tmo state", 32'(hz.dbg_state), 32'd0);
        check_perf("tmo");

        // Asynchronous reset mid-wait: everything drops within the same cycle.
        @(negedge clk);
        hz.EXMEM_mem_access    = 1'b1;
        hz.dmem_ready          = 1'b0;
        hz.EXMEM_WriteRegister = 5'd5;
        hz.EXMEM_reg_write     = 1'b1;
        hz.IDEX_inst25_21      = 5'd5;
        @(negedge clk);
        #1;
        check("arst pre state", 32'(hz.dbg_state), 32'd1);
        check("arst pre forward_a", 32'(hz.forward_a), 32'd2);
        #1;
        reset = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check_ctrl("arst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("arst state", 32'(hz.dbg_state), 32'd0);
        check("arst mem_timeout", 32'(hz.mem_timeout), 32'd0);
        check("arst forward_a", 32'(hz.forward_a), 32'd0);
        check_perf("arst");
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        #1;
        check("arst release pc_write", 32'(hz.pc_write), 32'd1);
        check("arst release mem_timeout", 32'(hz.mem_timeout), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, meaning max MEM_WAIT cycles before timeout is flagged (range 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port IFID_inst  input  32  instruction in IF/ID; rs=[25:21], rt=[20:16].
REQ-005 SHALL have port IDEX_inst25_21 / IDEX_inst20_16  input  5 each  rs/rt of instruction in ID/EX.
REQ-006 SHALL have port IDEX_mem_read  input  1  ID/EX instruction is a load.
REQ-007 SHALL have ports EXMEM_WriteRegister  input  5 and EXMEM_reg_write  input  1  EX/MEM destination and write enable.
REQ-008 SHALL have ports MEMWB_WriteRegister  input  5 and MEMWB_reg_write  input  1  MEM/WB destination and write enable.
REQ-009 SHALL have ports EXMEM_branch_taken  input  1 and EXMEM_mem_access  input  1  beq resolved taken / lw-sw in MEM.
REQ-010 SHALL have port dmem_ready  input  1  data memory completes access this cycle.
REQ-011 SHALL have outputs pc_write, IFID_write, IDEX_bubble, IFID_flush, IDEX_flush, EXMEM_flush, freeze, MEMWB_bubble, mem_timeout  1 each  pipeline control/status.
REQ-012 SHALL have outputs forward_a, forward_b  2 each  ALU operand select (00 regfile, 01 MEM/WB, 10 EX/MEM).
REQ-013 SHALL have outputs stall_cycles, flush_count  16 each  performance counters.

Function
REQ-014 SHALL define load_use = IDEX_mem_read & (IDEX_inst20_16!=0) & (IDEX_inst20_16==IFID_inst[25:21] | IDEX_inst20_16==IFID_inst[20:16]).
REQ-015 SHALL implement FSM states RUN and MEM_WAIT, registered on clk.
REQ-016 SHALL transition RUN->MEM_WAIT when EXMEM_mem_access=1 and dmem_ready=0; MEM_WAIT->RUN on the first cycle dmem_ready=1.
REQ-017 SHALL assert freeze=1, pc_write=0, IFID_write=0, MEMWB_bubble=1 combinationally whenever (state=MEM_WAIT or RUN entry condition) and dmem_ready=0; all flushes 0 during freeze.
REQ-018 SHALL give priority freeze > branch flush > load-use stall when events coincide.
REQ-019 SHALL, when not frozen and EXMEM_branch_taken=1, assert IFID_flush, IDEX_flush, EXMEM_flush for exactly that cycle with pc_write=1; load-use ignored that cycle.
REQ-020 SHALL, when not frozen, not flushing and load_use=1, drive pc_write=0, IFID_write=0, IDEX_bubble=1 for one cycle (zero-latency, combinational).
REQ-021 SHALL otherwise drive pc_write=1, IFID_write=1, all bubbles/flushes/freeze 0.
REQ-022 SHALL drive forward_a=10 if EXMEM_reg_write & EXMEM_WriteRegister!=0 & ==IDEX_inst25_21, else 01 on same test against MEMWB, else 00; forward_b identical using IDEX_inst20_16; EX/MEM wins when both match.
REQ-023 SHALL count consecutive MEM_WAIT cycles in an 8-bit counter cleared on RUN; reaching WAIT_LIMIT sets mem_timeout, sticky until reset; counter saturates.
REQ-024 SHALL increment stall_cycles on each cycle pc_write=0 and flush_count on each branch-flush cycle, both saturating at 16'hFFFF.

Reset
REQ-025 SHALL, while reset=0, force state RUN, wait counter 0, mem_timeout 0, stall_cycles 0, flush_count 0, and outputs pc_write=0, IFID_write=0, all flushes/bubbles/freeze 0, forward_a=forward_b=00.
REQ-026 SHALL, on reset assertion mid-MEM_WAIT, return to RUN immediately (asynchronous) and drop freeze.

Configuration
REQ-027 SHALL compile stall_cycles/flush_count logic only when macro HAZARD_PERF_EN is defined; undefined, both outputs are constant 0 and no counter flops exist.

Verification
REQ-028 IFID_inst=add $3,$2,$4, IDEX_mem_read=1, IDEX_inst20_16=2 -> pc_write=0, IFID_write=0, IDEX_bubble=1 for one cycle; stall_cycles +1.
REQ-029 EXMEM_branch_taken=1 with load_use=1 same cycle -> all three flushes=1, pc_write=1, IDEX_bubble=0; flush_count +1.
REQ-030 EXMEM_mem_access=1, dmem_ready=0 for 3 cycles then 1 -> freeze=1 for 3 cycles, state MEM_WAIT, back to RUN on 4th, stall_cycles +3.
REQ-031 WAIT_LIMIT=4, dmem_ready held 0 for 6 cycles -> mem_timeout=1 after 4th MEM_WAIT cycle, stays 1 after dmem_ready=1 until reset=0.
REQ-032 EXMEM and MEMWB both write $5, IDEX_inst25_21=5, IDEX_inst20_16=0 -> forward_a=10, forward_b=00; EXMEM_WriteRegister=0 -> forward_a=01.
REQ-033 reset=0 asserted in MEM_WAIT -> freeze=0, counters 0, pc_write=0 within same cycle; build without HAZARD_PERF_EN -> counters read 0 throughout.
